// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ENABLE    = 2'd0;
  localparam logic [1:0] ADDR_MODE      = 2'd1;
  localparam logic [1:0] ADDR_PENDING   = 2'd2;
  localparam logic [1:0] ADDR_INSERVICE = 2'd3;

  // Reset images, sliced down to NUM_IRQ by the controller.
  localparam logic [31:0] ENABLE_RST = 32'h0000_0000;
  localparam logic [31:0] MODE_RST   = 32'hFFFF_FFFF;

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for one interrupt line plus a history flop for edge detect.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability; s3 remembers the previous synchronised level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronise, latch/track, mask, prioritise and hand one
// request at a time to the core.
//
// Handshake: irq_req/irq_id are registered and stable while irq_req is high
// (irq_id may move to a higher-priority channel before ack). An irq_ack pulse is
// honoured only while irq_req is high (FSM in REQ) and accepts the channel in
// irq_id; irq_req drops on the following edge. An irq_eoi pulse is honoured only
// in SERVICE and ends service; no new request is raised until then.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  output logic [NUM_IRQ-1:0] cfg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output state_t             fsm_state
);

  logic [NUM_IRQ-1:0] sync_level, sync_rise;
  logic [NUM_IRQ-1:0] enable_q, mode_q, pend_q, pend_d, inservice_q;
  logic [NUM_IRQ-1:0] pending, eligible, ack_mask, w1c_mask;
  logic [ID_W-1:0]    winner, id_d;
  logic               any_eligible, ack_fire, eoi_fire, req_d;
  state_t             state_q, state_d;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    int_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .irq   (irq_in[i]),
      .level (sync_level[i]),
      .rise  (sync_rise[i])
    );
  end

  // Edge channels use the latched bit; level channels follow the synced line.
  assign pending      = (mode_q & pend_q) | (~mode_q & sync_level);
  assign eligible     = pending & enable_q;
  assign any_eligible = |eligible;
  assign ack_fire     = (state_q == ST_REQ) && irq_ack;
  assign eoi_fire     = (state_q == ST_SERVICE) && irq_eoi;

  // Fixed priority: scan downwards so the lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // Next edge-pending state: clears from ack/W1C, a same-cycle rise wins.
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i] = ack_fire && (irq_id == ID_W'(i));
    end
    w1c_mask = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata : '0;
    pend_d   = ((pend_q & ~(ack_mask | w1c_mask)) | sync_rise) & mode_q;
  end

  // Configuration, pending and in-service registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q    <= ENABLE_RST[NUM_IRQ-1:0];
      mode_q      <= MODE_RST[NUM_IRQ-1:0];
      pend_q      <= '0;
      inservice_q <= '0;
    end else begin
      if (cfg_we && cfg_addr == ADDR_ENABLE) enable_q <= cfg_wdata;
      if (cfg_we && cfg_addr == ADDR_MODE)   mode_q   <= cfg_wdata;
      pend_q <= pend_d;
      if (ack_fire)      inservice_q <= ack_mask;
      else if (eoi_fire) inservice_q <= '0;
    end
  end

  // FSM state and registered request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      state_q <= state_d;
      irq_req <= req_d;
      irq_id  <= id_d;
    end
  end

  // FSM next state; ack takes precedence over a vanishing eligible set.
  always_comb begin
    state_d = state_q;
    req_d   = irq_req;
    id_d    = irq_id;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          id_d    = winner;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_SERVICE;
          req_d   = 1'b0;
        end else if (!any_eligible) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else begin
          id_d = winner;
        end
      end
      ST_SERVICE: begin
        req_d = 1'b0;
        if (irq_eoi) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:    cfg_rdata = enable_q;
      ADDR_MODE:      cfg_rdata = mode_q;
      ADDR_PENDING:   cfg_rdata = pending;
      ADDR_INSERVICE: cfg_rdata = inservice_q;
      default:        cfg_rdata = '0;
    endcase
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: request events are checked by a scoreboard
// monitor, register and timing points by direct checks.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_IRQ-1:0] irq_in;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_eoi;
  state_t             fsm_state;

  int checks = 0;
  int errors = 0;
  logic [ID_W-1:0] exp_q[$];

  int_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi),
    .fsm_state (fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every new request (rise, or id change while high) pops one expectation.
  logic            prev_req = 1'b0;
  logic [ID_W-1:0] prev_id  = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (irq_req && (!prev_req || irq_id != prev_id)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL req_event: unexpected request id=%0d, none expected", irq_id);
        end else begin
          logic [ID_W-1:0] e;
          e = exp_q.pop_front();
          if (irq_id !== e) begin
            errors++;
            $display("FAIL req_event: id=%0d expected %0d", irq_id, e);
          end
        end
      end
      prev_req = irq_req;
      prev_id  = irq_id;
    end else begin
      prev_req = 1'b0;
      prev_id  = '0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [1:0] addr, input logic [NUM_IRQ-1:0] exp);
    cfg_addr = addr;
    #1;
    check(name, 32'(cfg_rdata), 32'(exp));
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [NUM_IRQ-1:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1;
    tick();
    irq_in[ch] = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [ID_W-1:0] id);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (irq_req && irq_id == id) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no request with id %0d within 20 cycles (req=%0b id=%0d)",
               name, id, irq_req, irq_id);
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    #22 rst = 1'b1;
    tick();

    // Reset state
    check_reg("rst_enable",  ADDR_ENABLE,  8'h00);
    check_reg("rst_mode",    ADDR_MODE,    8'hFF);
    check_reg("rst_pending", ADDR_PENDING, 8'h00);
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_fsm", 32'(fsm_state), 32'(ST_IDLE));

    // Edge capture and handshake on ch3
    cfg_write(ADDR_ENABLE, 8'hFF);
    exp_q.push_back(3'd3);
    pulse(3);
    tick(); tick();
    check("edge_req_early", 32'(irq_req), 32'd0);
    tick();
    check("edge_req_lat4", 32'(irq_req), 32'd1);
    check("edge_id", 32'(irq_id), 32'd3);
    do_ack();
    check("ack_req_drop", 32'(irq_req), 32'd0);
    check_reg("ack_inservice", ADDR_INSERVICE, 8'h08);
    check_reg("ack_pending",   ADDR_PENDING,   8'h00);
    do_eoi();
    check_reg("eoi_inservice", ADDR_INSERVICE, 8'h00);
    tick(); tick(); tick();
    check("eoi_req_idle", 32'(irq_req), 32'd0);

    // Priority / preemption before ack
    exp_q.push_back(3'd5);
    pulse(5);
    wait_req("pre_req5", 3'd5);
    exp_q.push_back(3'd1);
    pulse(1);
    wait_req("pre_req1", 3'd1);
    do_ack();
    check_reg("pre_inservice1", ADDR_INSERVICE, 8'h02);
    check_reg("pre_pending5",   ADDR_PENDING,   8'h20);
    exp_q.push_back(3'd5);
    do_eoi();
    wait_req("pre_req5_again", 3'd5);
    do_ack();
    check_reg("pre_inservice5", ADDR_INSERVICE, 8'h20);
    do_eoi();

    // Mask and W1C
    cfg_write(ADDR_ENABLE, 8'h00);
    pulse(2);
    tick(); tick();
    check_reg("mask_pending", ADDR_PENDING, 8'h04);
    check("mask_req", 32'(irq_req), 32'd0);
    cfg_write(ADDR_PENDING, 8'h04);
    check_reg("w1c_pending", ADDR_PENDING, 8'h00);
    cfg_write(ADDR_ENABLE, 8'h04);
    tick(); tick(); tick(); tick();
    check("w1c_no_req", 32'(irq_req), 32'd0);

    // Level mode on ch0
    cfg_write(ADDR_MODE, 8'hFE);
    cfg_write(ADDR_ENABLE, 8'h01);
    exp_q.push_back(3'd0);
    irq_in[0] = 1'b1;
    wait_req("lvl_req", 3'd0);
    do_ack();
    check("lvl_ack_drop", 32'(irq_req), 32'd0);
    check_reg("lvl_inservice", ADDR_INSERVICE, 8'h01);
    exp_q.push_back(3'd0);
    do_eoi();
    check("lvl_eoi_req_low", 32'(irq_req), 32'd0);
    tick();
    check("lvl_rereq", 32'(irq_req), 32'd1);
    check("lvl_rereq_id", 32'(irq_id), 32'd0);
    irq_in[0] = 1'b0;
    tick(); tick();
    check("lvl_drop_hold", 32'(irq_req), 32'd1);
    tick();
    check("lvl_drop_req", 32'(irq_req), 32'd0);
    check("lvl_drop_fsm", 32'(fsm_state), 32'(ST_IDLE));

    // Asynchronous reset while in SERVICE
    exp_q.push_back(3'd0);
    irq_in[0] = 1'b1;
    wait_req("rst_mid_req", 3'd0);
    do_ack();
    check("rst_mid_fsm_service", 32'(fsm_state), 32'(ST_SERVICE));
    #2;
    rst = 1'b0;
    irq_in[0] = 1'b0;
    #1;
    check("rst_mid_req", 32'(irq_req), 32'd0);
    check("rst_mid_fsm", 32'(fsm_state), 32'(ST_IDLE));
    check_reg("rst_mid_inservice", ADDR_INSERVICE, 8'h00);
    check_reg("rst_mid_pending",   ADDR_PENDING,   8'h00);
    check_reg("rst_mid_enable",    ADDR_ENABLE,    8'h00);
    check_reg("rst_mid_mode",      ADDR_MODE,      8'hFF);
    tick();
    #3 rst = 1'b1;
    tick(); tick(); tick(); tick();
    check("post_rst_req", 32'(irq_req), 32'd0);

    // Final report
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller between external interrupt lines and the MIPS core's interrupt input. It synchronises `NUM_IRQ` asynchronous request lines, latches edge-mode pulses or tracks level-mode lines, applies a per-channel enable mask, and selects the highest-priority pending channel. It presents one request to the core through a req/ack/eoi handshake, and the core reaches its configuration registers through a small write/read port.

## Interface
- `NUM_IRQ`, 8: number of interrupt channels, 1–32.
- `ID_W`, `$clog2(NUM_IRQ)` (minimum 1): width of the channel ID.

- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `irq_in`, input, `NUM_IRQ`: raw asynchronous interrupt lines, active-high.
- `cfg_we`, input, 1: configuration write strobe.
- `cfg_addr`, input, 2: register select. 0 = ENABLE, 1 = MODE, 2 = PENDING (write-1-to-clear), 3 = INSERVICE (read-only).
- `cfg_wdata`, input, `NUM_IRQ`: write data.
- `cfg_rdata`, output, `NUM_IRQ`: combinational read of the register selected by `cfg_addr`.
- `irq_req`, output, 1: interrupt request to the core, registered.
- `irq_id`, output, `ID_W`: ID of the requested channel. Valid while `irq_req` is high, registered.
- `irq_ack`, input, 1: the core accepts the request. One-cycle pulse.
- `irq_eoi`, input, 1: the core ends service of the in-service channel. One-cycle pulse.

## Operation
- Synchroniser per channel: two flops, s1 then s2, followed by a history flop s3.
- Rising edge of a channel is detected when `s2 & ~s3`.
- MODE bit = 1 (edge mode):
  - PENDING[i] sets on a detected rising edge.
  - PENDING[i] clears when the channel is acked, or when software writes 1 to that bit.
- MODE bit = 0 (level mode):
  - PENDING[i] follows s2 and is not latched.
  - Writes to PENDING have no effect on level-mode bits.
- Eligible set = PENDING & ENABLE.
- Priority is fixed: the lowest index wins.
- FSM, with states in the package: IDLE, REQ, SERVICE.
  - IDLE → REQ when the eligible set is non-zero. `irq_req` goes to 1 and `irq_id` loads the winning channel.
  - REQ, `irq_ack` = 1 → SERVICE.
    - INSERVICE[`irq_id`] sets.
    - An edge-mode pending bit for that channel clears.
    - `irq_req` drops.
  - REQ, eligible set becomes zero before ack (channel disabled, pending cleared, or level dropped) → IDLE. `irq_req` drops.
  - REQ, a higher-priority channel becomes eligible before ack → stay in REQ. `irq_id` updates to that channel.
  - SERVICE, `irq_eoi` = 1 → IDLE. INSERVICE clears. No nesting.
- `irq_ack` outside REQ is ignored. `irq_eoi` outside SERVICE is ignored.
- Same-cycle edge set and clear (ack or W1C) on one bit: set wins, so no edge is lost.
- Same-cycle `irq_ack` and `irq_eoi`: the FSM evaluates ack only, because the FSM is in REQ.
- A config write is visible to the FSM on the cycle after the write edge.
- Reset values:
  - ENABLE = 0 (all channels masked).
  - MODE = all 1 (edge mode).
  - PENDING = 0, INSERVICE = 0, sync and history flops = 0.
  - `irq_req` = 0, `irq_id` = 0, FSM = IDLE.
- Reset asserted mid-operation returns every register to these values immediately. Any outstanding request or service is dropped.

## Timing
- `irq_in` rises and meets setup at edge E0:
  - s1 = 1 after E0, s2 = 1 after E1.
  - PENDING set after E2.
  - `irq_req` = 1 after E3.
- Latency from `irq_in` to `irq_req` is therefore 4 edges.
- A pulse one clock wide is guaranteed to be captured in edge mode. Narrower pulses are not guaranteed.
- `irq_req` falls on the edge after the `irq_ack` cycle.
- From IDLE with a pending request, the earliest re-request is the edge after the eoi edge.
- `cfg_rdata` is combinational from `cfg_addr` and the register state.

## Structure
- Package `int_ctrl_pkg` holds:
  - the FSM state enum;
  - the `cfg_addr` constants `ADDR_ENABLE`, `ADDR_MODE`, `ADDR_PENDING`, `ADDR_INSERVICE`;
  - the reset constants for ENABLE and MODE.
- Sub-module `int_sync`, instanced once per channel: two-flop synchroniser plus history flop. Outputs the synchronised level and the rise pulse.
- The priority encoder, pending logic and FSM stay in `int_ctrl`.

## Test plan
- Reset behaviour: release reset with `irq_in` = 0.
  - Reads return ENABLE = 0x00, MODE = 0xFF, PENDING = 0x00.
  - `irq_req` = 0.
- Edge capture and handshake: ENABLE = 0xFF, 10 ns pulse on `irq_in[3]`.
  - `irq_req` = 1 with `irq_id` = 3, 4 edges after the pulse.
  - Ack: `irq_req` drops and INSERVICE = 0x08.
  - Eoi: INSERVICE = 0x00 and `irq_req` stays 0.
- Priority and preemption before ack: pend ch5, wait for `irq_req` with ID 5, then pend ch1 with no ack.
  - `irq_id` changes to 1.
  - Ack ch1, then eoi.
  - `irq_req` returns with ID 5.
- Mask and W1C: ENABLE = 0x00, pulse ch2.
  - PENDING = 0x04 and `irq_req` = 0.
  - Write PENDING = 0x04: PENDING = 0x00.
  - Set ENABLE = 0x04: no request.
- Level mode: MODE = 0xFE, ENABLE = 0x01, hold `irq_in[0]` high.
  - Request with ID 0.
  - Ack, then eoi while the line is still high: request re-asserts after one edge.
  - Drop the line during REQ: `irq_req` drops 3 edges later, FSM in IDLE.
- Reset mid-service: assert `rst` = 0 while in SERVICE.
  - `irq_req` = 0, INSERVICE = 0, PENDING = 0 immediately, without waiting for a clock.
